// File: rtl/text_pkg.sv
// Shared constants, the clear-FSM state type and the write-time character
// sanitiser for the on-screen text renderer.
package text_pkg;

  localparam int FONT_W = 8;
  localparam int FONT_H = 8;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] FONT_BASE   = 8'h20;
  localparam logic [7:0] ASCII_MAX   = 8'h5F;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_e;

  // The font ROM only holds glyphs 0x20..0x5F; anything else renders as blank.
  function automatic logic [7:0] sanitize_ascii(input logic [7:0] c);
    return ((c < FONT_BASE) || (c > ASCII_MAX)) ? ASCII_SPACE : c;
  endfunction

endpackage

// File: rtl/text_buffer.sv
// NUM_CHARS x 8 character store with a sanitising write port, a one-slot-per-cycle
// clear sweep (entered on clear or reset) and one asynchronous read port.
module text_buffer
  import text_pkg::*;
#(
  parameter  int NUM_CHARS = 16,
  localparam int IW        = $clog2(NUM_CHARS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_wr_en,
  input  logic [IW-1:0] i_wr_idx,
  input  logic [7:0]    i_wr_char,
  input  logic          i_clear,
  input  logic [IW-1:0] i_rd_idx,
  output logic [7:0]    o_rd_char,
  output logic          o_busy,
  output clr_state_e    o_state
);

  localparam logic [IW-1:0] LAST_SLOT = IW'(NUM_CHARS - 1);

  logic [7:0]    r_mem [NUM_CHARS];
  clr_state_e    r_state;
  clr_state_e    w_state_nxt;
  logic [IW-1:0] r_k;
  logic [IW-1:0] w_k_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLR_SWEEP;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    case (r_state)
      CLR_IDLE: begin
        if (i_clear) begin
          w_state_nxt = CLR_SWEEP;
          w_k_nxt     = '0;
        end
      end
      CLR_SWEEP: begin
        if (i_clear) begin
          w_k_nxt = '0;
        end else if (r_k == LAST_SLOT) begin
          w_state_nxt = CLR_IDLE;
          w_k_nxt     = '0;
        end else begin
          w_k_nxt = r_k + 1'b1;
        end
      end
      default: begin
        w_state_nxt = CLR_IDLE;
        w_k_nxt     = '0;
      end
    endcase
  end

  // The sweep owns the array while busy, so user writes are dropped then.
  always_ff @(posedge clk) begin
    if (r_state == CLR_SWEEP) begin
      r_mem[r_k] <= ASCII_SPACE;
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= sanitize_ascii(i_wr_char);
    end
  end

  assign o_rd_char = r_mem[i_rd_idx];
  assign o_busy    = (r_state == CLR_SWEEP);
  assign o_state   = r_state;

endmodule

// File: rtl/text_renderer.sv
// One on-screen text line: maps the pixel position into the text box, drives the
// font ROM address and produces text_on two cycles after hcount/vcount.
module text_renderer
  import text_pkg::*;
#(
  parameter  int NUM_CHARS  = 16,
  parameter  int ORIGIN_X   = 0,
  parameter  int ORIGIN_Y   = 0,
  parameter  int SCALE_LOG2 = 1,
  parameter  int CW         = 10,
  localparam int IW         = $clog2(NUM_CHARS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [7:0]    wr_char,
  input  logic          clear,
  output logic          busy,
  input  logic [CW-1:0] hcount,
  input  logic [CW-1:0] vcount,
  input  logic          video_on,
  output logic [7:0]    font_char,
  output logic [2:0]    font_row,
  input  logic [7:0]    font_bitmap,
  output logic          text_on,
  output clr_state_e    dbg_clr_state
);

  localparam logic [CW:0] BOX_W = (CW+1)'(NUM_CHARS * FONT_W);
  localparam logic [CW:0] BOX_H = (CW+1)'(FONT_H);

  logic [CW:0]   w_dx_full;
  logic [CW:0]   w_dy_full;
  logic [CW-1:0] w_dx;
  logic [CW-1:0] w_dy;
  logic          w_hit;
  logic [IW-1:0] w_idx;
  logic [7:0]    w_rd_char;

  logic          r_in_box;
  logic [2:0]    r_col;
  logic [7:0]    r_font_char;
  logic [2:0]    r_font_row;
  logic          r_text_on;

  // The extra top bit flags pixels left of / above the origin as outside.
  assign w_dx_full = {1'b0, hcount} - (CW+1)'(ORIGIN_X);
  assign w_dy_full = {1'b0, vcount} - (CW+1)'(ORIGIN_Y);
  assign w_dx      = w_dx_full[CW-1:0] >> SCALE_LOG2;
  assign w_dy      = w_dy_full[CW-1:0] >> SCALE_LOG2;
  assign w_hit     = video_on
                   & ~w_dx_full[CW] & ({1'b0, w_dx} < BOX_W)
                   & ~w_dy_full[CW] & ({1'b0, w_dy} < BOX_H);
  assign w_idx     = w_dx[IW+2:3];

  text_buffer #(.NUM_CHARS(NUM_CHARS)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (wr_en),
    .i_wr_idx  (wr_idx),
    .i_wr_char (wr_char),
    .i_clear   (clear),
    .i_rd_idx  (w_idx),
    .o_rd_char (w_rd_char),
    .o_busy    (busy),
    .o_state   (dbg_clr_state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_box    <= 1'b0;
      r_col       <= '0;
      r_font_char <= '0;
      r_font_row  <= '0;
      r_text_on   <= 1'b0;
    end else begin
      r_in_box    <= w_hit;
      r_col       <= w_dx[2:0];
      r_font_char <= w_hit ? (w_rd_char - FONT_BASE) : 8'h00;
      r_font_row  <= w_hit ? w_dy[2:0] : 3'd0;
      // Bit 7 of the bitmap is the leftmost glyph column.
      r_text_on   <= r_in_box & font_bitmap[3'd7 - r_col];
    end
  end

  assign font_char = r_font_char;
  assign font_row  = r_font_row;
  assign text_on   = r_text_on;

endmodule

// File: tb/tb_text_renderer.sv
// Bench for text_renderer with defaults (origin 0,0, scale 2x): directed edge cases
// plus random writes/pixels, checked by a queue-based scoreboard.
module tb_text_renderer;
  import text_pkg::*;

  localparam int NCH   = 16;
  localparam int PIX   = 2;            // screen pixels per font pixel
  localparam int BOX_W = NCH * 8 * PIX;
  localparam int BOX_H = 8 * PIX;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_idx = '0;
  logic [7:0] wr_char = '0;
  logic       clear = 1'b0;
  logic       busy;
  logic [9:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic       video_on = 1'b0;
  logic [7:0] font_char;
  logic [2:0] font_row;
  logic [7:0] font_bitmap;
  logic       text_on;
  clr_state_e dbg_clr_state;

  always #5 clk = ~clk;

  text_renderer dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_idx        (wr_idx),
    .wr_char       (wr_char),
    .clear         (clear),
    .busy          (busy),
    .hcount        (hcount),
    .vcount        (vcount),
    .video_on      (video_on),
    .font_char     (font_char),
    .font_row      (font_row),
    .font_bitmap   (font_bitmap),
    .text_on       (text_on),
    .dbg_clr_state (dbg_clr_state)
  );

  // Font ROM model: real 'A' glyph, blank space, arbitrary patterns elsewhere.
  function automatic logic [7:0] font_rom(input logic [7:0] c, input logic [2:0] r);
    logic [7:0] a_glyph [8];
    a_glyph = '{8'h30, 8'h78, 8'hCC, 8'hCC, 8'hFC, 8'hCC, 8'hCC, 8'h00};
    if (c == 8'h00) return 8'h00;
    if (c == 8'h21) return a_glyph[r];
    return (c * 8'd29) + ({5'b0, r} * 8'd71) + 8'h5A;
  endfunction

  assign font_bitmap = font_rom(font_char, font_row);

  typedef struct packed {
    logic       in_box;
    logic [7:0] fc;
    logic [2:0] row;
  } fexp_t;

  fexp_t      fc_q [$];
  logic [0:0] exp_q [$];
  logic [7:0] model_buf [NCH];
  int         n_vec = 0;
  int         n_err = 0;
  logic       scan_v = 1'b0;
  logic       v_d1 = 1'b0;
  logic       v_d2 = 1'b0;

  always @(posedge clk) begin
    v_d1 <= scan_v;
    v_d2 <= v_d1;
  end

  function automatic logic [7:0] clean_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h5F) return c;
    return 8'h20;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: font port one cycle after the pixel, text_on two cycles after.
  always @(negedge clk) begin
    fexp_t      f;
    logic [0:0] e;
    if (v_d1) begin
      n_vec++;
      if (fc_q.size() == 0) begin
        n_err++;
        $display("FAIL font_port: output with empty expectation queue");
      end else begin
        f = fc_q.pop_front();
        if (font_char !== f.fc || (f.in_box && font_row !== f.row)) begin
          n_err++;
          $display("FAIL font_port: got char %h row %0d, expected char %h row %0d",
                   font_char, font_row, f.fc, f.row);
        end
      end
    end
    if (v_d2) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL text_on: output with empty expectation queue");
      end else begin
        e = exp_q.pop_front();
        if (text_on !== e[0]) begin
          n_err++;
          $display("FAIL text_on: got %b, expected %b", text_on, e[0]);
        end
      end
    end
  end

  // One cycle of stimulus; the pixel sees the buffer before this cycle's write.
  task automatic step(input int x, input int y, input bit von, input bit pix,
                      input bit we, input int idx, input logic [7:0] ch);
    bit         inb;
    logic [7:0] c;
    logic [7:0] bm;
    int         col;
    int         row;
    @(negedge clk);
    hcount   = 10'(x);
    vcount   = 10'(y);
    video_on = von;
    scan_v   = pix;
    wr_en    = we;
    wr_idx   = 4'(idx);
    wr_char  = ch;
    if (pix) begin
      inb = von && (x < BOX_W) && (y < BOX_H);
      col = (x / PIX) % 8;
      row = (y / PIX) % 8;
      c   = inb ? model_buf[x / (8 * PIX)] : 8'h20;
      bm  = font_rom(c - 8'h20, 3'(row));
      fc_q.push_back('{in_box: inb, fc: (inb ? c - 8'h20 : 8'h00), row: 3'(row)});
      exp_q.push_back(inb ? bm[7 - col] : 1'b0);
    end
    if (we) model_buf[idx] = clean_char(ch);
  endtask

  task automatic pix(input int x, input int y);
    step(x, y, 1'b1, 1'b1, 1'b0, 0, 8'h00);
  endtask

  task automatic wr(input int idx, input logic [7:0] ch);
    step(0, 0, 1'b0, 1'b0, 1'b1, idx, ch);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0, 1'b0, 0, 8'h00);
  endtask

  // Reset pulse, optional clear after 5 sweep cycles, then measure busy length.
  // With a clear, a write is attempted on the 10th busy cycle of the new sweep.
  task automatic reset_sweep(input bit with_clear, output int cnt);
    @(negedge clk);
    scan_v = 1'b0;
    wr_en  = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    if (!with_clear) begin
      chk("reset_text_on", int'(text_on), 0);
      chk("reset_font_char", int'(font_char), 0);
      chk("reset_font_row", int'(font_row), 0);
    end else begin
      repeat (5) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
    end
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      cnt++;
      wr_en   = with_clear && (cnt == 10);
      wr_idx  = 4'd0;
      wr_char = 8'h41;
      @(negedge clk);
    end
    wr_en = 1'b0;
    for (int i = 0; i < NCH; i++) model_buf[i] = 8'h20;
  endtask

  initial begin
    int cnt;
    int x;
    int y;
    for (int i = 0; i < NCH; i++) model_buf[i] = 8'h20;
    repeat (2) @(posedge clk);

    // Reset: busy exactly 16 cycles, then an empty frame.
    reset_sweep(1'b0, cnt);
    chk("busy_after_reset", cnt, 16);
    for (int yy = 0; yy < 20; yy++)
      for (int xx = 0; xx < 300; xx++) pix(xx, yy);
    for (int xx = 1000; xx < 1024; xx++) pix(xx, 3);

    // 'A' in slot 0, row 0.
    wr(0, 8'h41);
    for (int xx = 0; xx < 20; xx++) pix(xx, 0);

    // 'A' in slot 15, row 1, plus right-edge and far-right pixels.
    wr(15, 8'h41);
    for (int xx = 236; xx < 262; xx++) pix(xx, 2);
    for (int xx = 1018; xx < 1024; xx++) pix(xx, 2);

    // Out-of-range code is stored as a space.
    wr(3, 8'h7A);
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 48; xx < 64; xx++) pix(xx, yy);

    // Same-cycle write and read of slot 2.
    step(32, 4, 1'b1, 1'b1, 1'b1, 2, 8'h41);
    pix(33, 4);
    pix(34, 4);
    idle(3);

    // Clear mid-sweep restarts it; the write during busy is dropped.
    reset_sweep(1'b1, cnt);
    chk("busy_after_clear", cnt, 16);
    chk("busy_low_after_sweep", int'(busy), 0);
    for (int xx = 0; xx < 20; xx++) pix(xx, 0);
    for (int xx = 0; xx < 20; xx++) pix(xx, 2);

    // Random writes and pixels.
    for (int i = 0; i < 3000; i++) begin
      x = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1000, 1023))
                                      : int'($urandom_range(0, 279));
      y = int'($urandom_range(0, 19));
      step(x, y, ($urandom_range(0, 9) != 0), 1'b1, ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, NCH - 1)), 8'($urandom_range(0, 255)));
    end
    idle(4);
    chk("font_queue_drained", fc_q.size(), 0);
    chk("text_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
